// File: rtl/ddr4_cmd_issuer.sv
// DDR4 command encoder: turns abstract requests into registered C/A pin cycles.
// Tracks the open row of each bank, enforces spacing timers, flags illegal requests
// and drives even C/A parity.
module ddr4_cmd_issuer #(
  parameter int unsigned pBG_BITS   = 2,
  parameter int unsigned pBA_BITS   = 2,
  parameter int unsigned pADDR_BITS = 14,
  parameter int unsigned pT_RCD     = 16,
  parameter int unsigned pT_RP      = 16,
  parameter int unsigned pT_AP      = 24,
  parameter int unsigned pT_CCD     = 4,
  parameter int unsigned pT_MRD     = 8,
  parameter int unsigned pT_RFC     = 260,
  parameter int unsigned pCKE_DLY   = 10
) (
  input  logic                  i_ck,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [2:0]            i_req_cmd,
  input  logic [pBG_BITS-1:0]   i_req_bg,
  input  logic [pBA_BITS-1:0]   i_req_ba,
  input  logic [16:0]           i_req_addr,
  output logic                  o_err_illegal,
  output logic                  o_cke,
  output logic                  o_cs_n,
  output logic                  o_act,
  output logic                  o_ras_n,
  output logic                  o_cas_n,
  output logic                  o_we_n,
  output logic [pBG_BITS-1:0]   o_bg,
  output logic [pBA_BITS-1:0]   o_ba,
  output logic [pADDR_BITS-1:0] o_addr,
  output logic                  o_parity
);

  localparam int unsigned BW = pBG_BITS + pBA_BITS;
  localparam int unsigned NB = 2 ** BW;
  // Wide enough for any single timer load value.
  localparam int unsigned TW = $clog2(pT_RCD + pT_RP + pT_AP + pT_CCD + pT_MRD + pT_RFC + 1);
  localparam int unsigned CW = $clog2(pCKE_DLY + 1);

  typedef enum logic [2:0] {
    CmdAct  = 3'd0,
    CmdRd   = 3'd1,
    CmdWr   = 3'd2,
    CmdPre  = 3'd3,
    CmdPrea = 3'd4,
    CmdRef  = 3'd5,
    CmdMrs  = 3'd6,
    CmdNop  = 3'd7
  } cmd_e;

  typedef enum logic {StInit, StRun} state_e;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
    return (v == '0) ? v : v - TW'(1);
  endfunction

  state_e           r_state, w_state_d;
  logic [CW-1:0]    r_cke_cnt, w_cke_cnt_d;
  logic             r_cke;

  logic [NB-1:0]    r_open, w_open_d;
  logic [TW-1:0]    r_bank_tmr [NB];
  logic [TW-1:0]    w_bank_tmr_d [NB];
  logic [TW-1:0]    r_ccd_tmr, w_ccd_tmr_d;
  logic [TW-1:0]    r_mrd_tmr, w_mrd_tmr_d;
  logic [TW-1:0]    r_rfc_tmr, w_rfc_tmr_d;

  cmd_e             w_cmd;
  logic [BW-1:0]    w_bank;
  logic             w_glob_ok, w_all_idle, w_any_open;
  logic             w_illegal, w_tmr_ok, w_ready, w_accept, w_issue;

  logic             w_cs_n, w_act, w_ras_n, w_cas_n, w_we_n, w_parity;
  logic [pBG_BITS-1:0]   w_bg;
  logic [pBA_BITS-1:0]   w_ba;
  logic [pADDR_BITS-1:0] w_addr;

  assign w_cmd      = cmd_e'(i_req_cmd);
  assign w_bank     = {i_req_bg, i_req_ba};
  assign w_any_open = |r_open;
  assign w_glob_ok  = (r_mrd_tmr == '0) && (r_rfc_tmr == '0);
  assign w_ready    = r_cke && (w_illegal || w_tmr_ok);
  assign w_accept   = i_req_valid && w_ready;
  assign w_issue    = w_accept && !w_illegal && (w_cmd != CmdNop);
  assign o_req_ready = w_ready;
  assign o_cke       = r_cke;

  // Init sequencing: hold cke low for pCKE_DLY cycles after reset release.
  always_comb begin
    w_state_d   = r_state;
    w_cke_cnt_d = r_cke_cnt;
    case (r_state)
      StInit: begin
        if (r_cke_cnt == CW'(pCKE_DLY - 1)) w_state_d = StRun;
        else                                 w_cke_cnt_d = r_cke_cnt + CW'(1);
      end
      StRun: ;
    endcase
  end

  // Legality and timer readiness of the presented request.
  always_comb begin
    w_all_idle = 1'b1;
    for (int i = 0; i < NB; i++) begin
      if (r_bank_tmr[i] != '0) w_all_idle = 1'b0;
    end
    w_illegal = 1'b0;
    w_tmr_ok  = 1'b1;
    case (w_cmd)
      CmdAct: begin
        w_illegal = r_open[w_bank];
        w_tmr_ok  = w_glob_ok && (r_bank_tmr[w_bank] == '0);
      end
      CmdRd, CmdWr: begin
        w_illegal = !r_open[w_bank];
        w_tmr_ok  = w_glob_ok && (r_bank_tmr[w_bank] == '0) && (r_ccd_tmr == '0);
      end
      CmdPre, CmdPrea: w_tmr_ok = w_glob_ok;
      CmdRef: begin
        w_illegal = w_any_open;
        w_tmr_ok  = w_glob_ok && w_all_idle;
      end
      CmdMrs: begin
        w_illegal = w_any_open;
        w_tmr_ok  = w_glob_ok;
      end
      default: ;
    endcase
  end

  // Bank state and timer next-state: decrement, then apply loads for an issued command.
  always_comb begin
    w_open_d    = r_open;
    w_ccd_tmr_d = sat_dec(r_ccd_tmr);
    w_mrd_tmr_d = sat_dec(r_mrd_tmr);
    w_rfc_tmr_d = sat_dec(r_rfc_tmr);
    for (int i = 0; i < NB; i++) w_bank_tmr_d[i] = sat_dec(r_bank_tmr[i]);
    if (w_issue) begin
      case (w_cmd)
        CmdAct: begin
          w_open_d[w_bank]     = 1'b1;
          w_bank_tmr_d[w_bank] = TW'(pT_RCD - 1);
        end
        CmdRd, CmdWr: begin
          w_ccd_tmr_d = TW'(pT_CCD - 1);
          if (i_req_addr[10]) begin
            w_open_d[w_bank]     = 1'b0;
            w_bank_tmr_d[w_bank] = TW'(pT_AP - 1);
          end
        end
        CmdPre: begin
          // A closed bank keeps its timer; it may still be finishing an auto-precharge.
          if (r_open[w_bank]) begin
            w_open_d[w_bank]     = 1'b0;
            w_bank_tmr_d[w_bank] = TW'(pT_RP - 1);
          end
        end
        CmdPrea: begin
          w_open_d = '0;
          for (int i = 0; i < NB; i++) begin
            if (w_bank_tmr_d[i] < TW'(pT_RP - 1)) w_bank_tmr_d[i] = TW'(pT_RP - 1);
          end
        end
        CmdRef:  w_rfc_tmr_d = TW'(pT_RFC - 1);
        CmdMrs:  w_mrd_tmr_d = TW'(pT_MRD - 1);
        default: ;
      endcase
    end
  end

  // Pin encoding for the next cycle; DES unless a command is issued.
  always_comb begin
    w_cs_n   = 1'b1;
    w_act    = 1'b1;
    w_ras_n  = 1'b1;
    w_cas_n  = 1'b1;
    w_we_n   = 1'b1;
    w_bg     = '0;
    w_ba     = '0;
    w_addr   = '0;
    w_parity = 1'b0;
    if (w_issue) begin
      w_cs_n = 1'b0;
      w_bg   = i_req_bg;
      w_ba   = i_req_ba;
      w_addr = i_req_addr[pADDR_BITS-1:0];
      case (w_cmd)
        CmdAct: begin
          w_act                     = 1'b0;
          {w_ras_n, w_cas_n, w_we_n} = i_req_addr[16:14];
        end
        CmdRd: w_cas_n = 1'b0;
        CmdWr: begin
          w_cas_n = 1'b0;
          w_we_n  = 1'b0;
        end
        CmdPre: begin
          w_ras_n    = 1'b0;
          w_we_n     = 1'b0;
          w_addr[10] = 1'b0;
        end
        CmdPrea: begin
          w_ras_n    = 1'b0;
          w_we_n     = 1'b0;
          w_addr[10] = 1'b1;
        end
        CmdRef: begin
          w_ras_n = 1'b0;
          w_cas_n = 1'b0;
        end
        CmdMrs: begin
          w_ras_n = 1'b0;
          w_cas_n = 1'b0;
          w_we_n  = 1'b0;
        end
        default: ;
      endcase
      w_parity = ^{w_act, w_ras_n, w_cas_n, w_we_n, w_bg, w_ba, w_addr};
    end
  end

  // Init state, cke and timer/bank registers.
  always_ff @(posedge i_ck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StInit;
      r_cke_cnt <= '0;
      r_cke     <= 1'b0;
      r_open    <= '0;
      r_ccd_tmr <= '0;
      r_mrd_tmr <= '0;
      r_rfc_tmr <= '0;
      for (int i = 0; i < NB; i++) r_bank_tmr[i] <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cke_cnt <= w_cke_cnt_d;
      r_cke     <= (w_state_d == StRun);
      r_open    <= w_open_d;
      r_ccd_tmr <= w_ccd_tmr_d;
      r_mrd_tmr <= w_mrd_tmr_d;
      r_rfc_tmr <= w_rfc_tmr_d;
      for (int i = 0; i < NB; i++) r_bank_tmr[i] <= w_bank_tmr_d[i];
    end
  end

  // Registered pins and illegal-request pulse.
  always_ff @(posedge i_ck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cs_n        <= 1'b1;
      o_act         <= 1'b1;
      o_ras_n       <= 1'b1;
      o_cas_n       <= 1'b1;
      o_we_n        <= 1'b1;
      o_bg          <= '0;
      o_ba          <= '0;
      o_addr        <= '0;
      o_parity      <= 1'b0;
      o_err_illegal <= 1'b0;
    end else begin
      o_cs_n        <= w_cs_n;
      o_act         <= w_act;
      o_ras_n       <= w_ras_n;
      o_cas_n       <= w_cas_n;
      o_we_n        <= w_we_n;
      o_bg          <= w_bg;
      o_ba          <= w_ba;
      o_addr        <= w_addr;
      o_parity      <= w_parity;
      o_err_illegal <= w_accept && w_illegal;
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_issuer.sv
// Bench for ddr4_cmd_issuer: absolute-time reference model feeding a scoreboard queue,
// with an independent monitor checking every output cycle.
module tb_ddr4_cmd_issuer;

  localparam int unsigned T_RCD = 16, T_RP = 16, T_AP = 24, T_CCD = 4;
  localparam int unsigned T_MRD = 8, T_RFC = 260, CKE_DLY = 10;
  localparam int unsigned WAIT_LIMIT = 400;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_cmd = 3'd7;
  logic [1:0]  req_bg = '0, req_ba = '0;
  logic [16:0] req_addr = '0;
  logic        err_illegal, cke, cs_n, act, ras_n, cas_n, we_n, parity;
  logic [1:0]  bg, ba;
  logic [13:0] addr;

  ddr4_cmd_issuer dut (
    .i_ck          (ck),
    .i_rst_n       (rst_n),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_cmd     (req_cmd),
    .i_req_bg      (req_bg),
    .i_req_ba      (req_ba),
    .i_req_addr    (req_addr),
    .o_err_illegal (err_illegal),
    .o_cke         (cke),
    .o_cs_n        (cs_n),
    .o_act         (act),
    .o_ras_n       (ras_n),
    .o_cas_n       (cas_n),
    .o_we_n        (we_n),
    .o_bg          (bg),
    .o_ba          (ba),
    .o_addr        (addr),
    .o_parity      (parity)
  );

  always #5 ck = ~ck;

  // Edge count: after edge N, cyc == N.
  int unsigned cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  int unsigned vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  typedef struct {
    int unsigned at_edge;
    bit          err;
    logic [3:0]  pins;   // {act, ras_n, cas_n, we_n}
    logic [1:0]  bg, ba;
    logic [13:0] addr;
    logic        par;
  } exp_t;

  exp_t sb[$];

  // Reference model: absolute edge at which each constraint is satisfied.
  bit          m_open [16];
  int unsigned m_free [16];
  int unsigned m_ccd, m_mrd, m_rfc, m_init;

  function automatic int unsigned mx(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic void model_reset(input int unsigned release_cyc);
    for (int i = 0; i < 16; i++) begin
      m_open[i] = 1'b0;
      m_free[i] = 0;
    end
    m_ccd  = 0;
    m_mrd  = 0;
    m_rfc  = 0;
    m_init = release_cyc + CKE_DLY + 1;
  endfunction

  // JEDEC truth-table encoding of a command.
  function automatic exp_t encode(input logic [2:0] cmd, input logic [1:0] b_g,
                                  input logic [1:0] b_a, input logic [16:0] a);
    exp_t e;
    e.bg   = b_g;
    e.ba   = b_a;
    e.addr = a[13:0];
    e.err  = 1'b0;
    e.at_edge = 0;
    case (cmd)
      3'd0: e.pins = {1'b0, a[16:14]};
      3'd1: e.pins = 4'b1101;
      3'd2: e.pins = 4'b1100;
      3'd3: begin e.pins = 4'b1010; e.addr[10] = 1'b0; end
      3'd4: begin e.pins = 4'b1010; e.addr[10] = 1'b1; end
      3'd5: e.pins = 4'b1001;
      default: e.pins = 4'b1000;
    endcase
    e.par = ^{e.pins, e.bg, e.ba, e.addr};
    return e;
  endfunction

  // Present one request (called at a negedge), predict its outcome, wait for acceptance.
  task automatic issue(input logic [2:0] cmd, input logic [1:0] b_g, input logic [1:0] b_a,
                       input logic [16:0] a);
    int unsigned t, b, n;
    bit ill, anyo;
    exp_t e;
    b = {28'd0, b_g, b_a};
    anyo = 1'b0;
    for (int i = 0; i < 16; i++) anyo |= m_open[i];
    ill = (cmd == 3'd0 && m_open[b]) || ((cmd == 3'd1 || cmd == 3'd2) && !m_open[b]) ||
          ((cmd == 3'd5 || cmd == 3'd6) && anyo);
    t = mx(cyc + 1, m_init);
    if (!ill) begin
      t = mx(t, mx(m_mrd, m_rfc));
      case (cmd)
        3'd0: t = mx(t, m_free[b]);
        3'd1, 3'd2: t = mx(t, mx(m_free[b], m_ccd));
        3'd5: for (int i = 0; i < 16; i++) t = mx(t, m_free[i]);
        default: ;
      endcase
      case (cmd)
        3'd0: begin m_open[b] = 1'b1; m_free[b] = t + T_RCD; end
        3'd1, 3'd2: begin
          m_ccd = t + T_CCD;
          if (a[10]) begin m_open[b] = 1'b0; m_free[b] = t + T_AP; end
        end
        3'd3: if (m_open[b]) begin m_open[b] = 1'b0; m_free[b] = t + T_RP; end
        3'd4: for (int i = 0; i < 16; i++) begin
          m_open[i] = 1'b0;
          m_free[i] = mx(m_free[i], t + T_RP);
        end
        3'd5: m_rfc = t + T_RFC;
        3'd6: m_mrd = t + T_MRD;
        default: ;
      endcase
    end
    if (cmd != 3'd7) begin
      e = encode(cmd, b_g, b_a, a);
      e.at_edge = t;
      e.err = ill;
      sb.push_back(e);
    end
    req_cmd = cmd;
    req_bg = b_g;
    req_ba = b_a;
    req_addr = a;
    req_valid = 1'b1;
    n = 0;
    #1;
    while (!req_ready && n < WAIT_LIMIT) begin
      @(negedge ck);
      n++;
    end
    if (!req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: cmd %0d never accepted, expected at edge %0d", cmd, t);
      if (cmd != 3'd7) void'(sb.pop_back());
      req_valid = 1'b0;
      return;
    end
    @(negedge ck);
    req_valid = 1'b0;
    req_cmd = 3'd7;
  endtask

  // Assert reset at a negedge, check async effect, release and check cke/ready ramp.
  task automatic do_reset(input int unsigned hold);
    @(negedge ck);
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_cmd = 3'd7;
    #1;
    chk("rst_cke", {31'd0, cke}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    sb.delete();
    repeat (hold) @(negedge ck);
    rst_n = 1'b1;
    model_reset(cyc);
    for (int i = 1; i <= int'(CKE_DLY); i++) begin
      @(negedge ck);
      chk("init_cke", {31'd0, cke}, (i == int'(CKE_DLY)) ? 32'd1 : 32'd0);
      chk("init_ready", {31'd0, req_ready}, (i == int'(CKE_DLY)) ? 32'd1 : 32'd0);
    end
  endtask

  // Monitor: every cycle either matches the head of the scoreboard or is DES.
  exp_t me;
  initial begin
    forever begin
      @(negedge ck);
      if (err_illegal || !cs_n) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: cs_n=%0b err_illegal=%0b at edge %0d",
                   cs_n, err_illegal, cyc);
        end else begin
          me = sb.pop_front();
          chk("accept_edge", cyc, me.at_edge);
          chk("err_illegal", {31'd0, err_illegal}, {31'd0, me.err});
          if (me.err) begin
            chk("illegal_des", {9'd0, cs_n, act, ras_n, cas_n, we_n, bg, ba, addr, parity},
                {9'd0, 5'b11111, 2'b0, 2'b0, 14'b0, 1'b0});
          end else begin
            chk("cs_n", {31'd0, cs_n}, 32'd0);
            chk("cmd_pins", {28'd0, act, ras_n, cas_n, we_n}, {28'd0, me.pins});
            chk("bg_ba", {28'd0, bg, ba}, {28'd0, me.bg, me.ba});
            chk("addr", {18'd0, addr}, {18'd0, me.addr});
            chk("parity", {31'd0, parity}, {31'd0, me.par});
          end
        end
      end else begin
        chk("des_pins", {9'd0, act, ras_n, cas_n, we_n, bg, ba, addr, parity},
            {9'd0, 4'hF, 2'b0, 2'b0, 14'b0, 1'b0});
      end
    end
  end

  logic [2:0] rc;
  int unsigned r;

  initial begin
    model_reset(0);
    do_reset(3);

    // Directed: ACT, RD after tRCD, RD after tCCD.
    issue(3'd0, 2'd0, 2'd1, 17'h1ABCD);
    issue(3'd1, 2'd0, 2'd1, 17'h00008);
    issue(3'd1, 2'd0, 2'd1, 17'h00010);
    // Illegal RD to closed bank, then a normal ACT there.
    issue(3'd1, 2'd2, 2'd3, 17'h00020);
    issue(3'd0, 2'd2, 2'd3, 17'h04321);
    // WR with auto-precharge, PRE to a closed bank, MRS illegal while open.
    issue(3'd2, 2'd2, 2'd3, 17'h00408);
    issue(3'd3, 2'd1, 2'd2, 17'h00000);
    issue(3'd6, 2'd0, 2'd2, 17'h00123);
    // PREA, REF after tRP, ACT after tRFC; MRS then ACT after tMRD.
    issue(3'd4, 2'd0, 2'd0, 17'h00000);
    issue(3'd5, 2'd0, 2'd0, 17'h00000);
    issue(3'd0, 2'd3, 2'd0, 17'h0F00F);
    issue(3'd3, 2'd3, 2'd0, 17'h00000);
    issue(3'd6, 2'd1, 2'd1, 17'h00A5A);
    issue(3'd0, 2'd1, 2'd0, 17'h12345);

    // Reset while a RD waits on tRCD; afterwards the bank is closed.
    issue(3'd0, 2'd1, 2'd1, 17'h00777);
    req_cmd = 3'd1;
    req_bg = 2'd1;
    req_ba = 2'd1;
    req_addr = 17'h00004;
    req_valid = 1'b1;
    repeat (3) begin
      @(negedge ck);
      chk("rd_waits_trcd", {31'd0, req_ready}, 32'd0);
    end
    do_reset(2);
    issue(3'd1, 2'd1, 2'd1, 17'h00004);

    // Randomized traffic over 8 banks.
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 99);
      if      (r < 30) rc = 3'd0;
      else if (r < 50) rc = 3'd1;
      else if (r < 68) rc = 3'd2;
      else if (r < 80) rc = 3'd3;
      else if (r < 85) rc = 3'd4;
      else if (r < 90) rc = 3'd7;
      else if (r < 95) rc = 3'd6;
      else             rc = 3'd5;
      issue(rc, 2'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 17'($urandom));
    end

    repeat (3) @(negedge ck);
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
